// File: rtl/matmul_pkg.sv
// matmul_pkg: shared widths and FSM state type for the matmul sequencer.
// Optional feature macro used by this slice: MATMUL_SEQ_ACC_EN.
package matmul_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned BUS_WIDTH   = 64;
  localparam int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned SP_NTARGETS = 4;
  localparam int unsigned DIM_W       = $clog2(MAX_DIM);
  localparam int unsigned SP_SEL_W    = $clog2(SP_NTARGETS);
  // One extra bit so the drain count (up to 2*MAX_DIM-1) cannot wrap
  localparam int unsigned CNT_W       = DIM_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: command, operand-memory, array and result-write signals.
// acc_mode_i exists only when MATMUL_SEQ_ACC_EN is defined.
interface matmul_sequencer_if;
  import matmul_pkg::*;

  logic                  start_i;
  logic [DIM_W-1:0]      n_dim_i;
  logic [DIM_W-1:0]      k_dim_i;
  logic [DIM_W-1:0]      m_dim_i;
  logic [SP_SEL_W-1:0]   sp_target_i;
`ifdef MATMUL_SEQ_ACC_EN
  logic                  acc_mode_i;
`endif
  logic                  busy_o;
  logic                  done_o;
  logic                  op_rd_en_o;
  logic [DIM_W-1:0]      op_rd_addr_o;
  logic [BUS_WIDTH-1:0]  a_rd_data_i;
  logic [BUS_WIDTH-1:0]  b_rd_data_i;
  logic [BUS_WIDTH-1:0]  a_feed_o;
  logic [BUS_WIDTH-1:0]  b_feed_o;
  logic                  pe_en_o;
  logic                  pe_clr_o;
  logic                  res_we_o;
  logic [DIM_W-1:0]      res_row_o;
  logic [SP_SEL_W-1:0]   res_target_o;

  // Sequencer side
  modport master (
`ifdef MATMUL_SEQ_ACC_EN
    input  acc_mode_i,
`endif
    input  start_i, n_dim_i, k_dim_i, m_dim_i, sp_target_i,
    input  a_rd_data_i, b_rd_data_i,
    output busy_o, done_o, op_rd_en_o, op_rd_addr_o,
    output a_feed_o, b_feed_o, pe_en_o, pe_clr_o,
    output res_we_o, res_row_o, res_target_o
  );

  // Controller / memory / array side
  modport slave (
`ifdef MATMUL_SEQ_ACC_EN
    output acc_mode_i,
`endif
    output start_i, n_dim_i, k_dim_i, m_dim_i, sp_target_i,
    output a_rd_data_i, b_rd_data_i,
    input  busy_o, done_o, op_rd_en_o, op_rd_addr_o,
    input  a_feed_o, b_feed_o, pe_en_o, pe_clr_o,
    input  res_we_o, res_row_o, res_target_o
  );

endinterface

// File: rtl/matmul_skew_line.sv
// matmul_skew_line: DEPTH-stage shift register delaying one operand lane.
module matmul_skew_line #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_sr [DEPTH];

  // Shift one element per cycle; reset clears every stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_data;
      for (int unsigned k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_data = r_sr[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: clear / feed / drain / write control for the systolic array.
// MATMUL_SEQ_ACC_EN adds acc_mode_i, which skips CLEAR so results accumulate.
module matmul_sequencer
  import matmul_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  matmul_sequencer_if.master bus
);

  seq_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DIM_W-1:0]      r_n_dim, r_k_dim, r_m_dim;
  logic [SP_SEL_W-1:0]   r_target;
  logic                  w_acc_req;

  logic                  r_busy, r_done, r_op_rd_en, r_pe_en, r_pe_clr, r_res_we, r_rd_vld;
  logic [DIM_W-1:0]      r_op_rd_addr, r_res_row;
  logic [SP_SEL_W-1:0]   r_res_target;
  logic                  w_busy_nxt, w_done_nxt, w_op_rd_en_nxt, w_pe_en_nxt;
  logic                  w_pe_clr_nxt, w_res_we_nxt;
  logic [DIM_W-1:0]      w_op_rd_addr_nxt, w_res_row_nxt;
  logic [SP_SEL_W-1:0]   w_res_target_nxt;

`ifdef MATMUL_SEQ_ACC_EN
  assign w_acc_req = bus.acc_mode_i;
`else
  assign w_acc_req = 1'b0;
`endif

  // State and phase counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Job shadow registers, captured only when a start is accepted in IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_n_dim  <= '0;
      r_k_dim  <= '0;
      r_m_dim  <= '0;
      r_target <= '0;
    end else if (r_state == IDLE && bus.start_i) begin
      r_n_dim  <= bus.n_dim_i;
      r_k_dim  <= bus.k_dim_i;
      r_m_dim  <= bus.m_dim_i;
      r_target <= bus.sp_target_i;
    end
  end

  // Next state/count, and outputs decoded from the next state so they register cleanly
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: if (bus.start_i) begin
        w_state_nxt = w_acc_req ? FEED : CLEAR;
        w_cnt_nxt   = '0;
      end
      CLEAR: begin
        w_state_nxt = FEED;
        w_cnt_nxt   = '0;
      end
      FEED: if (r_cnt == CNT_W'(r_k_dim)) begin
        w_state_nxt = DRAIN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      DRAIN: if (r_cnt == CNT_W'(r_n_dim) + CNT_W'(r_m_dim)) begin
        w_state_nxt = WRITE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      WRITE: if (r_cnt == CNT_W'(r_n_dim)) begin
        w_state_nxt = DONE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt       = (w_state_nxt != IDLE);
    w_done_nxt       = (w_state_nxt == DONE);
    w_pe_clr_nxt     = (w_state_nxt == CLEAR);
    w_op_rd_en_nxt   = (w_state_nxt == FEED);
    w_op_rd_addr_nxt = (w_state_nxt == FEED) ? DIM_W'(w_cnt_nxt) : '0;
    w_pe_en_nxt      = ((w_state_nxt == FEED) && (w_cnt_nxt != '0)) || (w_state_nxt == DRAIN);
    w_res_we_nxt     = (w_state_nxt == WRITE);
    w_res_row_nxt    = (w_state_nxt == WRITE) ? DIM_W'(w_cnt_nxt) : '0;
    w_res_target_nxt = (w_state_nxt == WRITE) ? r_target : '0;
  end

  // Registered outputs; r_rd_vld marks the cycle operand data returns
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pe_clr     <= 1'b0;
      r_op_rd_en   <= 1'b0;
      r_op_rd_addr <= '0;
      r_pe_en      <= 1'b0;
      r_res_we     <= 1'b0;
      r_res_row    <= '0;
      r_res_target <= '0;
      r_rd_vld     <= 1'b0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pe_clr     <= w_pe_clr_nxt;
      r_op_rd_en   <= w_op_rd_en_nxt;
      r_op_rd_addr <= w_op_rd_addr_nxt;
      r_pe_en      <= w_pe_en_nxt;
      r_res_we     <= w_res_we_nxt;
      r_res_row    <= w_res_row_nxt;
      r_res_target <= w_res_target_nxt;
      r_rd_vld     <= r_op_rd_en;
    end
  end

  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.pe_clr_o     = r_pe_clr;
  assign bus.op_rd_en_o   = r_op_rd_en;
  assign bus.op_rd_addr_o = r_op_rd_addr;
  assign bus.pe_en_o      = r_pe_en;
  assign bus.res_we_o     = r_res_we;
  assign bus.res_row_o    = r_res_row;
  assign bus.res_target_o = r_res_target;

  logic [DATA_WIDTH-1:0] w_a_lane [MAX_DIM];
  logic [DATA_WIDTH-1:0] w_b_lane [MAX_DIM];
  logic [DATA_WIDTH-1:0] w_a_skew [MAX_DIM];
  logic [DATA_WIDTH-1:0] w_b_skew [MAX_DIM];

  // Zero lanes outside the job dims, and all lanes when no read data is valid
  always_comb begin
    for (int unsigned i = 0; i < MAX_DIM; i++) begin
      w_a_lane[i] = (r_rd_vld && DIM_W'(i) <= r_n_dim) ?
                    bus.a_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      w_b_lane[i] = (r_rd_vld && DIM_W'(i) <= r_m_dim) ?
                    bus.b_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  assign w_a_skew[0] = w_a_lane[0];
  assign w_b_skew[0] = w_b_lane[0];

  for (genvar g = 1; g < MAX_DIM; g++) begin : g_skew
    matmul_skew_line #(.DEPTH(g), .DATA_WIDTH(DATA_WIDTH)) u_a_skew (
      .clk_i (clk_i), .rst_i (rst_i), .i_data (w_a_lane[g]), .o_data (w_a_skew[g])
    );
    matmul_skew_line #(.DEPTH(g), .DATA_WIDTH(DATA_WIDTH)) u_b_skew (
      .clk_i (clk_i), .rst_i (rst_i), .i_data (w_b_lane[g]), .o_data (w_b_skew[g])
    );
  end

  for (genvar g = 0; g < MAX_DIM; g++) begin : g_feed
    assign bus.a_feed_o[g*DATA_WIDTH +: DATA_WIDTH] = w_a_skew[g];
    assign bus.b_feed_o[g*DATA_WIDTH +: DATA_WIDTH] = w_b_skew[g];
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control sequencer for the MAX_DIM×MAX_DIM output-stationary systolic matrix-multiply array. On a start command it clears the PE accumulators and reads operand lanes from the A and B operand memories. It feeds those lanes into the array with per-lane diagonal skew, then waits for the wavefront to drain. Finally it issues one result-row write per output row toward the selected scratchpad target and pulses done.

## Interface
- DATA_WIDTH, 16, operand element width
- BUS_WIDTH, 64, operand lane width (MAX_DIM elements)
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, array dimension
- SP_NTARGETS, 4, number of scratchpad targets
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start request, sampled only in IDLE
- n_dim_i  in  DIM_W  rows of A minus 1
- k_dim_i  in  DIM_W  inner dimension minus 1
- m_dim_i  in  DIM_W  columns of B minus 1
- sp_target_i  in  SP_SEL_W  destination scratchpad for C
- busy_o  out  1  high from accepted start until done_o cycle inclusive
- done_o  out  1  single-cycle completion pulse
- op_rd_en_o  out  1  operand read strobe
- op_rd_addr_o  out  DIM_W  k index: A column k, B row k
- a_rd_data_i  in  BUS_WIDTH  A[*][k], lane i = element i; valid 1 cycle after strobe
- b_rd_data_i  in  BUS_WIDTH  B[k][*], lane j = element j; valid 1 cycle after strobe
- a_feed_o  out  BUS_WIDTH  skewed A lanes into array left edge
- b_feed_o  out  BUS_WIDTH  skewed B lanes into array top edge
- pe_en_o  out  1  array MAC enable
- pe_clr_o  out  1  array accumulator clear
- res_we_o  out  1  result-row write strobe
- res_row_o  out  DIM_W  result row index
- res_target_o  out  SP_SEL_W  latched scratchpad target

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, WRITE, DONE.
- IDLE: when start_i=1, latch the dims and target into shadow registers → CLEAR. Inputs are ignored in every state other than IDLE.
- CLEAR: pe_clr_o=1 for one cycle → FEED.
- FEED: K=k_dim+1 cycles.
  - op_rd_en_o=1 with op_rd_addr_o = kcnt = 0..K-1.
  - pe_en_o=1 from the second FEED cycle onward.
  - After the last FEED cycle → DRAIN.
- Skew: lane i of A is delayed i cycles after read-data arrival; lane j of B is delayed j cycles. Lane 0 is passed through unregistered.
- Masking: lanes with i>n_dim (A) or j>m_dim (B) are forced to zero before the skew. When no read data is valid, zeros are shifted in.
- DRAIN: N+M-1 cycles (N=n_dim+1, M=m_dim+1), pe_en_o=1 → WRITE.
- WRITE: N cycles, res_we_o=1, res_row_o=0..N-1, res_target_o=latched target → DONE.
- DONE: done_o=1, busy_o=1, one cycle → IDLE.
- Counters are DIM_W+1 bits wide so the drain count up to 2·MAX_DIM-1 does not wrap.

## Timing
- Reset value of every output is 0. FSM=IDLE, all counters and skew registers are cleared.
- Cycle 0 is the start_i sample. State sequence: CLEAR at cycle 1, FEED at cycles 2..K+1, DRAIN for N+M-1 cycles, WRITE for N cycles, DONE 1 cycle.
- Start-to-done latency: 1+K+(N+M-1)+N+1 cycles. For 4×4×4 this is 1+4+7+4+1 = 17.
- busy_o rises the cycle after start_i is accepted.
- start_i in the DONE cycle is ignored. A start in the following IDLE cycle is accepted, giving one dead cycle between jobs.
- rst_i asserted mid-operation aborts immediately: no write strobes, no done_o.
- Dims equal to 0 (1×1×1) are legal: FEED 1, DRAIN 1, WRITE 1.

## Configuration
- MATMUL_SEQ_ACC_EN defined:
  - Adds the input port acc_mode_i (1 bit), latched in IDLE with start_i.
  - When latched high, CLEAR is skipped (IDLE → FEED) and pe_clr_o stays 0, so C += A·B. Latency is reduced by 1.
- MATMUL_SEQ_ACC_EN undefined: the port is absent and CLEAR always executes.

## Structure
- matmul_pkg gains:
  - DIM_W = $clog2(MAX_DIM)
  - SP_SEL_W = $clog2(SP_NTARGETS)
  - typedef enum logic [2:0] seq_state_t with the six states
- Sub-module matmul_skew_line: a parameterised DEPTH-stage DATA_WIDTH shift register with async reset. It is instantiated once per nonzero lane for A and for B.

## Test plan
- 4×4×4 with A=identity, B[r][c]=r*4+c, target 2 → res_we_o high cycles 13–16, rows 0..3, res_target_o=2, done_o at cycle 17. Array C equals B.
- 1×1×1 with A=3, B=5 → latency 5, one write row 0, C[0][0]=15, other lanes of a_feed_o/b_feed_o stay 0.
- 2×3×4 (n_dim=1, k_dim=2, m_dim=3) → FEED 3 cycles with addresses 0,1,2, DRAIN 5, WRITE rows 0,1. A lanes 2–3 are always 0.
- start_i held high through a job → exactly one done_o, next job starts 1 cycle after DONE, busy_o low for 1 cycle between jobs.
- rst_i pulsed in DRAIN → all outputs 0 asynchronously, no res_we_o, next start runs the full latency.
- With MATMUL_SEQ_ACC_EN and acc_mode_i=1 on a repeat of the identity job → pe_clr_o never asserted, latency 16, C=2·B.
